// File: rtl/reg_wb_queue.sv
// -----------------------------------------------------------------------------
// reg_wb_queue
//
// Purpose:
//   Write-side producer for the register bank. Register-writeback results from
//   the execute/memory stages are buffered in a small FIFO. The FIFO drains one
//   entry per clock onto the bank write port (AW / DIN / REG_WRITE).
//   Writebacks that target register 0 complete their handshake but are never
//   stored, because register 0 is never written.
//
// Optional feature (macro REG_WB_QUEUE_FWD_EN):
//   Defined   : combinational forwarding lookups on AR1/AR2 search the entries
//               still resident in the FIFO. The youngest match wins, and
//               AR==0 never hits. The entry already presented on AW/DIN is
//               visible in the bank, so it is not searched.
//   Undefined : no lookup logic is built. FWD*_HIT and FWD*_DATA are tied
//               to 0, and AR1/AR2 are ignored.
//
// Ports:
//   CLK                   clock, rising edge
//   RST_N                 asynchronous active-low reset
//   IN_VALID/IN_READY     producer handshake (IN_READY == !full)
//   IN_AW, IN_DATA        destination register and result value
//   DRAIN_EN              bank may be written this cycle (0 stalls the drain)
//   AW, DIN, REG_WRITE    registered bank write port (REG_WRITE pulses once
//                         per committed entry)
//   AR1, AR2              bank read addresses snooped for forwarding
//   FWD1_HIT/FWD1_DATA    forwarding result for AR1
//   FWD2_HIT/FWD2_DATA    forwarding result for AR2
//   COUNT                 current FIFO occupancy
// -----------------------------------------------------------------------------
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [AWIDTH-1:0]        IN_AW,
  input  logic [WIDTH-1:0]         IN_DATA,
  input  logic                     DRAIN_EN,
  output logic [AWIDTH-1:0]        AW,
  output logic [WIDTH-1:0]         DIN,
  output logic                     REG_WRITE,
  input  logic [AWIDTH-1:0]        AR1,
  input  logic [AWIDTH-1:0]        AR2,
  output logic                     FWD1_HIT,
  output logic                     FWD2_HIT,
  output logic [WIDTH-1:0]         FWD1_DATA,
  output logic [WIDTH-1:0]         FWD2_DATA,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0]        CNT_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]        CNT_ONE   = (PW+1)'(1'b1);
  localparam logic [PW:0]        CNT_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]      PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]      PTR_ONE   = PW'(1'b1);
  localparam logic [AWIDTH-1:0]  AW_ZERO   = {AWIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   DATA_ZERO = {WIDTH{1'b0}};

  // FIFO storage. The contents need no reset: only slots inside the
  // head..head+count window are ever read.
  logic [AWIDTH-1:0] aw_mem_r   [DEPTH];
  logic [WIDTH-1:0]  data_mem_r [DEPTH];

  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [PW:0]       count_r;
  logic              ready_r;

  logic [AWIDTH-1:0] aw_r;
  logic [WIDTH-1:0]  din_r;
  logic              we_r;

  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic [PW:0]       count_next_s;

  // Handshake decode. A register-0 writeback is accepted but not stored.
  always_comb begin
    accept_s = IN_VALID & ready_r;
    push_s   = accept_s & (IN_AW != AW_ZERO);
    pop_s    = (count_r != CNT_ZERO) & DRAIN_EN;
  end

  // Next occupancy. A simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy, ready flag and the registered bank write port.
  // ready_r follows the count, so a pop at full raises IN_READY one cycle
  // later and not in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      ready_r <= 1'b1;
      aw_r    <= AW_ZERO;
      din_r   <= DATA_ZERO;
      we_r    <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ready_r <= (count_next_s != CNT_FULL);
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
        aw_r   <= aw_mem_r[head_r];
        din_r  <= data_mem_r[head_r];
        we_r   <= 1'b1;
      end else begin
        head_r <= head_r;
        aw_r   <= aw_r;
        din_r  <= din_r;
        we_r   <= 1'b0;
      end
    end
  end

  // Entry storage write at the tail slot.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      aw_mem_r[tail_r]   <= IN_AW;
      data_mem_r[tail_r] <= IN_DATA;
    end
  end

  assign IN_READY  = ready_r;
  assign AW        = aw_r;
  assign DIN       = din_r;
  assign REG_WRITE = we_r;
  assign COUNT     = count_r;

`ifdef REG_WB_QUEUE_FWD_EN
  // Walk from the oldest to the youngest resident entry. Later matches
  // overwrite earlier ones, so the youngest match wins. Result is {hit, data}.
  function automatic logic [WIDTH:0] fwd_lookup(input logic [AWIDTH-1:0] ar);
    logic             hit;
    logic [WIDTH-1:0] val;
    logic [PW-1:0]    idx;
    hit = 1'b0;
    val = DATA_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_r + PW'(i);
      if (((PW+1)'(i) < count_r) && (ar != AW_ZERO) && (aw_mem_r[idx] == ar)) begin
        hit = 1'b1;
        val = data_mem_r[idx];
      end else begin
        hit = hit;
        val = val;
      end
    end
    return {hit, val};
  endfunction

  logic [WIDTH:0] fwd1_s;
  logic [WIDTH:0] fwd2_s;

  // Forwarding lookups for both read ports.
  always_comb begin
    fwd1_s = fwd_lookup(AR1);
    fwd2_s = fwd_lookup(AR2);
  end

  assign FWD1_HIT  = fwd1_s[WIDTH];
  assign FWD1_DATA = fwd1_s[WIDTH-1:0];
  assign FWD2_HIT  = fwd2_s[WIDTH];
  assign FWD2_DATA = fwd2_s[WIDTH-1:0];
`else
  // Forwarding not built. The read addresses are intentionally unused.
  logic unused_ar_s;
  assign unused_ar_s = ^{AR1, AR2};

  assign FWD1_HIT  = 1'b0;
  assign FWD1_DATA = DATA_ZERO;
  assign FWD2_HIT  = 1'b0;
  assign FWD2_DATA = DATA_ZERO;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_queue
//
// Self-checking bench for reg_wb_queue (DEPTH=4, WIDTH=32, AWIDTH=5).
// A table of directed vectors covers basic writes, the register-0 drop,
// simultaneous push/pop and duplicate destinations. Hand sequences cover
// fill/stall, full-with-pop, forwarding priority and asynchronous reset in
// the middle of a drain. A randomized phase compares every cycle against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_reg_wb_queue;
  localparam int DEPTH  = 4;
  localparam int WIDTH  = 32;
  localparam int AWIDTH = 5;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              IN_VALID;
  logic              IN_READY;
  logic [AWIDTH-1:0] IN_AW;
  logic [WIDTH-1:0]  IN_DATA;
  logic              DRAIN_EN;
  logic [AWIDTH-1:0] AW;
  logic [WIDTH-1:0]  DIN;
  logic              REG_WRITE;
  logic [AWIDTH-1:0] AR1;
  logic [AWIDTH-1:0] AR2;
  logic              FWD1_HIT;
  logic              FWD2_HIT;
  logic [WIDTH-1:0]  FWD1_DATA;
  logic [WIDTH-1:0]  FWD2_DATA;
  logic [2:0]        COUNT;

  always #5 CLK = ~CLK;

  reg_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_AW(IN_AW), .IN_DATA(IN_DATA), .DRAIN_EN(DRAIN_EN),
    .AW(AW), .DIN(DIN), .REG_WRITE(REG_WRITE), .AR1(AR1), .AR2(AR2),
    .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
    .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA), .COUNT(COUNT)
  );

  int checks   = 0;
  int failures = 0;
  bit fwd_on;

  // Reference model: a plain queue of pending writes plus the bank port.
  typedef struct {
    logic [AWIDTH-1:0] aw;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t            q[$];
  logic              m_we;
  logic [AWIDTH-1:0] m_aw;
  logic [WIDTH-1:0]  m_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we  = 1'b0;
    m_aw  = '0;
    m_din = '0;
  endtask

  function automatic logic [WIDTH:0] m_fwd(input logic [AWIDTH-1:0] ar);
    if (!fwd_on || ar == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].aw == ar) return {1'b1, q[i].data};
    return '0;
  endfunction

  task automatic compare_model();
    logic [WIDTH:0] f1;
    logic [WIDTH:0] f2;
    f1 = m_fwd(AR1);
    f2 = m_fwd(AR2);
    check("m_reg_write", REG_WRITE, m_we);
    check("m_aw", AW, m_aw);
    check("m_din", DIN, m_din);
    check("m_count", COUNT, q.size());
    check("m_in_ready", IN_READY, q.size() < DEPTH);
    check("m_fwd1_hit", FWD1_HIT, f1[WIDTH]);
    check("m_fwd1_data", FWD1_DATA, f1[WIDTH-1:0]);
    check("m_fwd2_hit", FWD2_HIT, f2[WIDTH]);
    check("m_fwd2_data", FWD2_DATA, f2[WIDTH-1:0]);
  endtask

  // Drive one cycle of inputs, advance the model, clock, and compare.
  task automatic step(input logic v, input logic [AWIDTH-1:0] a, input logic [WIDTH-1:0] d,
                      input logic dr, input logic [AWIDTH-1:0] r1, input logic [AWIDTH-1:0] r2,
                      output bit acc);
    entry_t e;
    IN_VALID = v;
    IN_AW    = a;
    IN_DATA  = d;
    DRAIN_EN = dr;
    AR1      = r1;
    AR2      = r2;
    acc = v && (q.size() < DEPTH);
    if (q.size() > 0 && dr) begin
      e     = q.pop_front();
      m_we  = 1'b1;
      m_aw  = e.aw;
      m_din = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc && a != 0) begin
      e.aw   = a;
      e.data = d;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic              v;
    logic [AWIDTH-1:0] a;
    logic [WIDTH-1:0]  d;
    logic              dr;
    logic [AWIDTH-1:0] r1;
    logic              we;
    logic [AWIDTH-1:0] eaw;
    logic [WIDTH-1:0]  edin;
    int                ecnt;
    logic              eh1;
    logic [WIDTH-1:0]  ed1;
  } vec_t;

  vec_t vt[11];

  initial begin
    bit                acc;
    logic              hv;
    logic [AWIDTH-1:0] ha;
    logic [WIDTH-1:0]  hd;
    logic [AWIDTH-1:0] exp_aw[3];
    logic [WIDTH-1:0]  exp_din[3];

`ifdef REG_WB_QUEUE_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif

    //          v     a      d          dr    r1     we    eaw    edin      cnt eh1   ed1
    vt[0]  = '{1'b1, 5'd3, 32'hAA,    1'b1, 5'd3, 1'b0, 5'd0, 32'h0,    1, 1'b1, 32'hAA};
    vt[1]  = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd3, 1'b1, 5'd3, 32'hAA,   0, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 1'b0, 5'd3, 32'hAA,   0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 5'd0, 32'hDEAD,  1'b1, 5'd0, 1'b0, 5'd3, 32'hAA,   0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 5'd7, 32'h77,    1'b1, 5'd0, 1'b0, 5'd3, 32'hAA,   1, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 1'b1, 5'd7, 32'h77,   0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 1'b0, 5'd7, 32'h77,   0, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 5'd2, 32'h22,    1'b1, 5'd2, 1'b0, 5'd7, 32'h77,   1, 1'b1, 32'h22};
    vt[8]  = '{1'b1, 5'd2, 32'h23,    1'b1, 5'd2, 1'b1, 5'd2, 32'h22,   1, 1'b1, 32'h23};
    vt[9]  = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd2, 1'b0, 5'd2, 32'h22,   1, 1'b1, 32'h23};
    vt[10] = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd2, 1'b1, 5'd2, 32'h23,   0, 1'b0, 32'h0};

    // Reset state
    RST_N = 1'b0; IN_VALID = 1'b0; IN_AW = '0; IN_DATA = '0;
    DRAIN_EN = 1'b0; AR1 = '0; AR2 = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_reg_write", REG_WRITE, 1'b0);
    check("rst_aw", AW, 5'd0);
    check("rst_din", DIN, 32'd0);
    check("rst_count", COUNT, 3'd0);
    check("rst_fwd1_hit", FWD1_HIT, 1'b0);
    check("rst_fwd2_data", FWD2_DATA, 32'd0);
    RST_N = 1'b1;
    #1;
    check("rst_in_ready", IN_READY, 1'b1);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      step(vt[i].v, vt[i].a, vt[i].d, vt[i].dr, vt[i].r1, 5'd0, acc);
      check($sformatf("vec%0d_reg_write", i), REG_WRITE, vt[i].we);
      check($sformatf("vec%0d_aw", i), AW, vt[i].eaw);
      check($sformatf("vec%0d_din", i), DIN, vt[i].edin);
      check($sformatf("vec%0d_count", i), COUNT, vt[i].ecnt);
      check($sformatf("vec%0d_fwd1_hit", i), FWD1_HIT, vt[i].eh1 & fwd_on);
      check($sformatf("vec%0d_fwd1_data", i), FWD1_DATA, fwd_on ? vt[i].ed1 : 32'h0);
      check($sformatf("vec%0d_fwd2_hit", i), FWD2_HIT, 1'b0);
    end

    // Fill and stall, then drain with the fifth entry held at full
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(17 * i), 1'b0, 5'd0, 5'd0, acc);
    check("fill_count", COUNT, 3'd4);
    check("fill_ready", IN_READY, 1'b0);
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 5'd0, acc);
    check("fill_hold_count", COUNT, 3'd4);
    check("fill_hold_ready", IN_READY, 1'b0);
    check("fill_hold_we", REG_WRITE, 1'b0);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 5'd0, acc);
    check("full_pop_accept", acc, 1'b0);
    check("full_pop_we", REG_WRITE, 1'b1);
    check("full_pop_aw", AW, 5'd1);
    check("full_pop_count", COUNT, 3'd3);
    check("full_pop_ready_next", IN_READY, 1'b1);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 5'd0, acc);
    check("push5_accept", acc, 1'b1);
    check("drain_aw2", AW, 5'd2);
    check("drain_din2", DIN, 32'h22);
    check("drain_count2", COUNT, 3'd3);
    exp_aw[0] = 5'd3;  exp_aw[1] = 5'd4;  exp_aw[2] = 5'd5;
    exp_din[0] = 32'h33; exp_din[1] = 32'h44; exp_din[2] = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, acc);
      check($sformatf("drain%0d_we", i), REG_WRITE, 1'b1);
      check($sformatf("drain%0d_aw", i), AW, exp_aw[i]);
      check($sformatf("drain%0d_din", i), DIN, exp_din[i]);
    end
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, acc);
    check("drain_done_we", REG_WRITE, 1'b0);
    check("drain_done_count", COUNT, 3'd0);

    // Forwarding priority: youngest duplicate wins, AR==0 never hits
    step(1'b1, 5'd9, 32'h100, 1'b0, 5'd9, 5'd0, acc);
    step(1'b1, 5'd9, 32'h200, 1'b0, 5'd9, 5'd0, acc);
    check("fwd_pri_hit1", FWD1_HIT, fwd_on);
    check("fwd_pri_data1", FWD1_DATA, fwd_on ? 32'h200 : 32'h0);
    check("fwd_pri_hit2", FWD2_HIT, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, acc);
    check("fwd_after_pop_data1", FWD1_DATA, fwd_on ? 32'h200 : 32'h0);
    check("fwd_after_pop_hit2", FWD2_HIT, fwd_on);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, acc);
    check("fwd_empty_hit1", FWD1_HIT, 1'b0);
    check("fwd_dup_aw", AW, 5'd9);
    check("fwd_dup_din", DIN, 32'h200);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, acc);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) step(1'b1, 5'(10 + i), 32'(16'hA0 + i), 1'b0, 5'd0, 5'd0, acc);
    check("mid_count3", COUNT, 3'd3);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, acc);
    check("mid_we", REG_WRITE, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_we", REG_WRITE, 1'b0);
    check("arst_aw", AW, 5'd0);
    check("arst_din", DIN, 32'd0);
    check("arst_count", COUNT, 3'd0);
    model_reset();
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd11, acc);
      check($sformatf("post_rst%0d_we", i), REG_WRITE, 1'b0);
    end

    // Randomized traffic against the reference model
    hv = 1'b0; ha = '0; hd = '0; acc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(hv && !acc)) begin
        hv = ($urandom_range(0, 9) < 7);
        ha = 5'($urandom_range(0, 7));
        hd = $urandom;
      end
      step(hv, ha, hd, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), acc);
    end
    repeat (8) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, acc);
    check("final_count", COUNT, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
